// File: rtl/vme_dtack_ctrl.sv
// VME slave handshake: turns decoder strobes plus per-device acks into DTACK_B / BERR_OUT_B.
// Optional ACK/ERR entry counters are compiled in with `define VME_HANDSHAKE_STATS_EN.
module vme_dtack_ctrl #(
    localparam int unsigned NUM_DEV = 10,
    localparam int unsigned CNT_W   = 8,
    localparam int unsigned STAT_W  = 16,
    parameter logic [NUM_DEV-1:0] AUTO_ACK_MASK = 10'h001,
    parameter int unsigned        AUTO_DLY      = 3,
    parameter int unsigned        TMO_CYCLES    = 200
) (
    input  logic               FASTCLK,
    input  logic               RST_B,
    input  logic               STROBE,
    input  logic               STRBCE,
    input  logic [NUM_DEV-1:0] DEVICE,
    input  logic [NUM_DEV-1:0] DEV_ACK,
`ifdef VME_HANDSHAKE_STATS_EN
    input  logic               STATS_CLR,
    output logic [STAT_W-1:0]  ACK_CNT,
    output logic [STAT_W-1:0]  ERR_CNT,
`endif
    output logic               DTACK_B,
    output logic               BERR_OUT_B,
    output logic               BUSY,
    output logic               TIMEOUT
);

    localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_DLY - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TMO_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WAIT = 3'd1,
        ACK  = 3'd2,
        ERR  = 3'd3,
        REL  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_DEV-1:0] dev_sel_q, dev_sel_d;
    logic               dtack_b_d, berr_b_d, busy_d, timeout_d;
    logic               auto_hit, dev_hit, ack_hit;

    // Auto-acked devices complete on a fixed count; others on their own (in-select) DEV_ACK.
    assign auto_hit = (|(dev_sel_q & AUTO_ACK_MASK)) && (cnt_q == AUTO_LAST);
    assign dev_hit  = |(dev_sel_q & ~AUTO_ACK_MASK & DEV_ACK);
    assign ack_hit  = auto_hit || dev_hit;

    always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dev_sel_q  <= '0;
            DTACK_B    <= 1'b1;
            BERR_OUT_B <= 1'b1;
            BUSY       <= 1'b0;
            TIMEOUT    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dev_sel_q  <= dev_sel_d;
            DTACK_B    <= dtack_b_d;
            BERR_OUT_B <= berr_b_d;
            BUSY       <= busy_d;
            TIMEOUT    <= timeout_d;
        end
    end

    // Next state; master abort outranks ack, and ack outranks timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dev_sel_d = dev_sel_q;
        timeout_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (STRBCE) begin
                    if (DEVICE != '0) begin
                        dev_sel_d = DEVICE;
                        cnt_d     = '0;
                        state_d   = WAIT;
                    end else begin
                        state_d = ERR;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!STROBE) begin
                    state_d = IDLE;
                end else if (ack_hit) begin
                    state_d = ACK;
                end else if (cnt_q == TMO_LAST) begin
                    state_d   = ERR;
                    timeout_d = 1'b1;
                end
            end
            ACK: begin
                if (!STROBE) state_d = REL;
            end
            ERR: begin
                if (!STROBE) state_d = REL;
            end
            REL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        dtack_b_d = (state_d != ACK);
        berr_b_d  = (state_d != ERR);
        busy_d    = (state_d != IDLE);
    end

`ifdef VME_HANDSHAKE_STATS_EN
    logic ack_entry, err_entry;

    assign ack_entry = (state_d == ACK) && (state_q != ACK);
    assign err_entry = (state_d == ERR) && (state_q != ERR);

    // Saturating entry counters; a synchronous clear beats a same-cycle increment.
    always_ff @(posedge FASTCLK or negedge RST_B) begin
        if (!RST_B) begin
            ACK_CNT <= '0;
            ERR_CNT <= '0;
        end else if (STATS_CLR) begin
            ACK_CNT <= '0;
            ERR_CNT <= '0;
        end else begin
            if (ack_entry && (ACK_CNT != '1)) ACK_CNT <= ACK_CNT + STAT_W'(1);
            if (err_entry && (ERR_CNT != '1)) ERR_CNT <= ERR_CNT + STAT_W'(1);
        end
    end
`endif

endmodule

// File: doc/vme_dtack_ctrl.md
Name: vme_dtack_ctrl

Overview:
- Downstream of the VME command decoder. Consumes its synchronised strobe (STROBE, STRBCE) and one-hot DEVICE select, plus per-device acknowledges.
- Generates the VME slave handshake: DTACK_B on success, BERR_OUT_B on timeout or an unmapped device.
- Closes every VME cycle the decoder opens, and guarantees DTACK_B/BERR_OUT_B release once the master drops its data strobes.

Parameters:
- AUTO_ACK_MASK, 10'h001, per-device bit. 1 means the device is acked by this block after AUTO_DLY cycles and its DEV_ACK is ignored. 0 means wait for DEV_ACK.
- AUTO_DLY, 3, cycles from the STRBCE sample to DTACK_B assertion for auto-acked devices. Range 1..254.
- TMO_CYCLES, 200, WAIT cycles before a bus error. Range AUTO_DLY+1..255. The counter is 8 bits.

Ports:
- FASTCLK  in  1  system clock, same net that drives the decoder strobe synchroniser
- RST_B  in  1  asynchronous, active-low reset
- STROBE  in  1  synchronised data-strobe-valid from decoder; drops asynchronously when DS0_B/DS1_B release
- STRBCE  in  1  one-cycle pulse on STROBE rising
- DEVICE  in  10  one-hot device decode, stable while STROBE=1
- DEV_ACK  in  10  per-device done, level, FASTCLK-synchronous
- DTACK_B  out  1  VME data acknowledge, active low, registered
- BERR_OUT_B  out  1  VME bus error, active low, registered
- BUSY  out  1  high in any state other than IDLE
- TIMEOUT  out  1  one-cycle pulse on entry to ERR caused by timeout

Behaviour:
- Reset (RST_B=0, async) forces: state=IDLE, DTACK_B=1, BERR_OUT_B=1, BUSY=0, TIMEOUT=0, cnt=0, dev_sel=0.
  - A reset mid-cycle releases DTACK_B/BERR_OUT_B immediately, without waiting for a clock edge.
- All outputs are registered on the FASTCLK rising edge.
- IDLE:
  - On an edge with STRBCE=1 and DEVICE!=0: latch dev_sel=DEVICE, cnt=0, go to WAIT.
  - On an edge with STRBCE=1 and DEVICE==0: go to ERR (unmapped device). TIMEOUT is not pulsed.
- WAIT:
  - cnt increments each edge.
  - ack_hit = |(dev_sel & AUTO_ACK_MASK) & (cnt==AUTO_DLY-1), OR |(dev_sel & ~AUTO_ACK_MASK & DEV_ACK).
  - If ack_hit, go to ACK. DTACK_B falls on that edge.
  - Else if cnt==TMO_CYCLES-1, go to ERR with TIMEOUT=1 for one cycle.
  - If ack_hit and timeout occur on the same edge, ack wins.
  - If STROBE=0 (master abort), go to IDLE with no DTACK_B/BERR_OUT_B.
  - Abort is checked first.
- Auto-ack latency: DTACK_B is low after the AUTO_DLY-th edge following the STRBCE-sampling edge.
- DEV_ACK latency: one edge after DEV_ACK is sampled high.
- ACK: hold DTACK_B=0 while STROBE=1. On an edge with STROBE=0: DTACK_B=1, go to REL.
- ERR: hold BERR_OUT_B=0 while STROBE=1. On an edge with STROBE=0: BERR_OUT_B=1, go to REL.
- REL: one dead cycle, then IDLE.
  - STRBCE is ignored in REL and in every non-IDLE state, which guarantees at least one cycle between successive handshakes.
- DTACK_B and BERR_OUT_B are never both low.
- DEV_ACK bits outside dev_sel are ignored. DEV_ACK held high from a previous cycle only counts once a new WAIT is entered.

Optional Feature:
- Macro: VME_HANDSHAKE_STATS_EN.
- Defined:
  - Adds outputs ACK_CNT[15:0] (count of ACK entries) and ERR_CNT[15:0] (count of ERR entries).
  - Both counters saturate at 16'hFFFF and clear on RST_B.
  - Adds input STATS_CLR, synchronous, which clears both counters. If STATS_CLR coincides with an increment, the clear wins.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- DEVICE=10'h001, STRBCE at edge 0, AUTO_DLY=3 -> DTACK_B=0 after edge 3. Drop STROBE at edge 10 -> DTACK_B=1 after edge 10, BUSY=0 after edge 11.
- DEVICE=10'h040 (not auto), DEV_ACK[6] rises before edge 5 -> DTACK_B=0 after edge 5. DEV_ACK[3] high throughout -> no effect.
- DEVICE=10'h080, no DEV_ACK, TMO_CYCLES=200 -> TIMEOUT pulse and BERR_OUT_B=0 after edge 200, DTACK_B stays 1. STROBE low -> BERR_OUT_B=1 on the next edge.
- DEVICE=0 with STRBCE -> BERR_OUT_B=0 after edge 1, TIMEOUT stays 0.
- DEV_ACK[6] rises exactly at the timeout edge -> DTACK_B=0, BERR_OUT_B=1, TIMEOUT=0. STROBE drop at edge 2 of WAIT -> IDLE, no ack asserted.
- RST_B pulsed low while DTACK_B=0 -> DTACK_B=1 immediately, before the next edge. With VME_HANDSHAKE_STATS_EN: 3 ACKs and 1 ERR -> ACK_CNT=3, ERR_CNT=1. STATS_CLR -> both 0.
